// File: rtl/rcb_frl_msg_tx_framer.sv
// Purpose: byte-wide transmit framer for the FRL message lane (training, idle fill, SOF+payload+CRC-8 frames).
// Latency: a message accepted at cycle t shows SOF at t+1, payload byte k at t+2+k, CRC at t+2+MSG_LEN.
// Backpressure: msg_ready is high in IDLE and in the CRC cycle (unless training is pending); one byte leaves every clock.
module rcb_frl_msg_tx_framer #(
    parameter int          MSG_LEN       = 4,
    parameter int          TRAIN_CYCLES  = 64,
    parameter logic [7:0]  TRAIN_PATTERN = 8'h5C,
    parameter logic [7:0]  IDLE_PATTERN  = 8'hC5,
    parameter logic [7:0]  SOF_BYTE      = 8'hF5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*MSG_LEN-1:0]   msg_data,
    input  logic                   msg_valid,
    output logic                   msg_ready,
    input  logic                   train_req,
    output logic [7:0]             out_data,
    output logic                   out_oce,
    output logic                   train_done,
    output logic [15:0]            msg_count
);

    localparam int         TOP        = 8*MSG_LEN-1;
    localparam logic [9:0] TRAIN_LAST = 10'(TRAIN_CYCLES);
    localparam logic [4:0] LAST_IDX   = 5'(MSG_LEN-1);

    // The state names the byte currently on out_data; every decision made
    // at a clock edge therefore picks the byte shown in the following cycle.
    typedef enum logic [2:0] {
        ST_TRAIN,
        ST_IDLE,
        ST_SOF,
        ST_PAYLOAD,
        ST_CRC
    } state_t;

    state_t             state, state_nxt;
    logic [9:0]         train_cnt, train_cnt_nxt;
    logic [4:0]         byte_idx, byte_idx_nxt;
    logic [8*MSG_LEN-1:0] shreg, shreg_nxt;
    logic [7:0]         crc, crc_nxt;
    logic               train_pend, train_pend_nxt;
    logic [7:0]         out_data_nxt;
    logic               msg_ready_nxt;
    logic [15:0]        msg_count_nxt;
    logic               handshake;
    logic               start_train;

    // One byte of CRC-8 (poly 0x07), MSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int i = 0; i < 8; i++) begin
            c = {c[6:0], 1'b0} ^ (c[7] ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    assign handshake = msg_valid & msg_ready;

    // Next-state and next-output selection for the byte shown next cycle.
    always_comb begin
        state_nxt      = state;
        train_cnt_nxt  = train_cnt;
        byte_idx_nxt   = byte_idx;
        shreg_nxt      = shreg;
        crc_nxt        = crc;
        train_pend_nxt = train_pend;
        out_data_nxt   = IDLE_PATTERN;
        msg_ready_nxt  = 1'b0;
        msg_count_nxt  = msg_count;
        start_train    = 1'b0;

        case (state)
            ST_TRAIN: begin
                // Counter holds the number of training bytes already shown.
                if (train_cnt == TRAIN_LAST) begin
                    state_nxt     = ST_IDLE;
                    train_cnt_nxt = 10'd0;
                    out_data_nxt  = IDLE_PATTERN;
                    msg_ready_nxt = 1'b1;
                end else begin
                    train_cnt_nxt = train_cnt + 10'd1;
                    out_data_nxt  = TRAIN_PATTERN;
                end
            end

            ST_IDLE, ST_CRC: begin
                // A training request outranks a message offered in the same cycle.
                start_train = train_pend | train_req;
                if (start_train) begin
                    state_nxt      = ST_TRAIN;
                    train_cnt_nxt  = 10'd1;
                    train_pend_nxt = 1'b0;
                    out_data_nxt   = TRAIN_PATTERN;
                end else if (handshake) begin
                    state_nxt    = ST_SOF;
                    shreg_nxt    = msg_data;
                    crc_nxt      = 8'h00;
                    out_data_nxt = SOF_BYTE;
                end else begin
                    state_nxt     = ST_IDLE;
                    out_data_nxt  = IDLE_PATTERN;
                    msg_ready_nxt = 1'b1;
                end
            end

            ST_SOF, ST_PAYLOAD: begin
                train_pend_nxt = train_pend | train_req;
                if (state == ST_PAYLOAD && byte_idx == LAST_IDX) begin
                    // crc already folds in every payload byte shown so far.
                    state_nxt     = ST_CRC;
                    out_data_nxt  = crc;
                    msg_ready_nxt = ~(train_pend | train_req);
                    msg_count_nxt = msg_count + 16'd1;
                end else begin
                    state_nxt    = ST_PAYLOAD;
                    out_data_nxt = shreg[TOP -: 8];
                    crc_nxt      = crc8_byte(crc, shreg[TOP -: 8]);
                    shreg_nxt    = shreg << 8;
                    byte_idx_nxt = (state == ST_SOF) ? 5'd0 : byte_idx + 5'd1;
                end
            end

            default: begin
                state_nxt     = ST_TRAIN;
                train_cnt_nxt = 10'd0;
            end
        endcase
    end

    // State and registered outputs; reset parks the lane at the start of a training burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_TRAIN;
            train_cnt  <= 10'd0;
            byte_idx   <= 5'd0;
            shreg      <= '0;
            crc        <= 8'h00;
            train_pend <= 1'b0;
            out_data   <= 8'h00;
            out_oce    <= 1'b0;
            msg_ready  <= 1'b0;
            train_done <= 1'b0;
            msg_count  <= 16'd0;
        end else begin
            state      <= state_nxt;
            train_cnt  <= train_cnt_nxt;
            byte_idx   <= byte_idx_nxt;
            shreg      <= shreg_nxt;
            crc        <= crc_nxt;
            train_pend <= train_pend_nxt;
            out_data   <= out_data_nxt;
            out_oce    <= 1'b1;
            msg_ready  <= msg_ready_nxt;
            train_done <= (state_nxt != ST_TRAIN);
            msg_count  <= msg_count_nxt;
        end
    end

endmodule

// File: tb/tb_rcb_frl_msg_tx_framer.sv
`timescale 1ns/1ps
module tb_rcb_frl_msg_tx_framer;

    localparam int ML = 4;
    localparam int TC = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] msg_data;
    logic        msg_valid, train_req;
    logic        msg_ready, out_oce, train_done;
    logic [7:0]  out_data;
    logic [15:0] msg_count;

    logic [71:0] d9;
    logic        v9, t9, r9, oce9, td9;
    logic [7:0]  o9;
    logic [15:0] c9;

    always #5 clk = ~clk;

    rcb_frl_msg_tx_framer #(.MSG_LEN(ML), .TRAIN_CYCLES(TC)) dut (
        .clk(clk), .rst(rst), .msg_data(msg_data), .msg_valid(msg_valid),
        .msg_ready(msg_ready), .train_req(train_req), .out_data(out_data),
        .out_oce(out_oce), .train_done(train_done), .msg_count(msg_count));

    rcb_frl_msg_tx_framer #(.MSG_LEN(9), .TRAIN_CYCLES(TC)) dut9 (
        .clk(clk), .rst(rst), .msg_data(d9), .msg_valid(v9),
        .msg_ready(r9), .train_req(t9), .out_data(o9),
        .out_oce(oce9), .train_done(td9), .msg_count(c9));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference CRC: remainder of payload*x^8 modulo x^8+x^2+x+1, by long division bit by bit.
    function automatic logic [7:0] crc_ref(input logic [127:0] v, input int n);
        logic [7:0] r;
        logic       b, top;
        r = 8'h00;
        for (int i = 8*n-1; i >= -8; i--) begin
            b   = (i >= 0) ? v[i] : 1'b0;
            top = r[7];
            r   = {r[6:0], b};
            if (top) r = r ^ 8'h07;
        end
        return r;
    endfunction

    // Behavioural model: a queue of bytes scheduled to leave the lane.
    localparam int K_TRN = 0, K_FRM = 1, K_CRC = 2, K_IDLE = 3, K_RST = 4;
    typedef struct packed { logic [7:0] b; logic [2:0] k; } ent_t;
    ent_t        q[$];
    int          cur_k;
    logic [7:0]  cur_b;
    bit          pend;
    logic [15:0] m_cnt;

    function automatic void m_reset();
        q.delete();
        for (int i = 0; i < TC; i++) q.push_back('{8'h5C, 3'(K_TRN)});
        cur_k = K_RST; cur_b = 8'h00; pend = 1'b0; m_cnt = 16'd0;
    endfunction

    function automatic bit m_ready();
        return (cur_k == K_IDLE) || (cur_k == K_CRC && !pend);
    endfunction

    function automatic void m_step(input bit v, input bit t, input logic [31:0] d);
        bit   rdy;
        ent_t e;
        rdy = m_ready();
        if ((cur_k == K_FRM || cur_k == K_CRC) && t) pend = 1'b1;
        if (q.size() == 0 && (cur_k == K_CRC || cur_k == K_IDLE)) begin
            if (pend || t) begin
                for (int i = 0; i < TC; i++) q.push_back('{8'h5C, 3'(K_TRN)});
                pend = 1'b0;
            end else if (v && rdy) begin
                q.push_back('{8'hF5, 3'(K_FRM)});
                for (int i = 0; i < ML; i++) q.push_back('{d[8*(ML-1-i) +: 8], 3'(K_FRM)});
                q.push_back('{crc_ref({96'b0, d}, ML), 3'(K_CRC)});
            end
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            cur_k = int'(e.k); cur_b = e.b;
            if (cur_k == K_CRC) m_cnt = m_cnt + 16'd1;
        end else begin
            cur_k = K_IDLE; cur_b = 8'hC5;
        end
    endfunction

    bit chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) m_reset();
        else m_step(msg_valid, train_req, msg_data);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_data",  {24'b0, out_data}, {24'b0, cur_b});
            chk("model_oce",   {31'b0, out_oce},   {31'b0, cur_k != K_RST});
            chk("model_ready", {31'b0, msg_ready}, {31'b0, m_ready()});
            chk("model_done",  {31'b0, train_done}, {31'b0, cur_k != K_TRN && cur_k != K_RST});
            chk("model_count", {16'b0, msg_count}, {16'b0, m_cnt});
        end
    end

    typedef struct { logic v; logic [31:0] d; logic [7:0] ed; logic er; } vec_t;
    vec_t tbl[20];

    initial begin
        logic [7:0] crc_a, crc_b, crc_c;
        msg_valid = 1'b0; train_req = 1'b0; msg_data = '0;
        v9 = 1'b0; t9 = 1'b0; d9 = '0;
        m_reset();

        crc_a = crc_ref(128'hF5F5F5F5, 4);
        crc_b = crc_ref(128'h12345678, 4);
        crc_c = crc_ref(128'hDEADBEEF, 4);
        tbl[0]  = '{1'b1, 32'h00000001, 8'hF5, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,        8'h00, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,        8'h00, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,        8'h00, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,        8'h01, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,        8'h07, 1'b1};
        tbl[6]  = '{1'b0, 32'h0,        8'hC5, 1'b1};
        tbl[7]  = '{1'b1, 32'hF5F5F5F5, 8'hF5, 1'b0};
        tbl[8]  = '{1'b1, 32'h12345678, 8'hF5, 1'b0};
        tbl[9]  = '{1'b1, 32'h12345678, 8'hF5, 1'b0};
        tbl[10] = '{1'b1, 32'h12345678, 8'hF5, 1'b0};
        tbl[11] = '{1'b1, 32'h12345678, 8'hF5, 1'b0};
        tbl[12] = '{1'b1, 32'h12345678, crc_a, 1'b1};
        tbl[13] = '{1'b1, 32'h12345678, 8'hF5, 1'b0};
        tbl[14] = '{1'b0, 32'h0,        8'h12, 1'b0};
        tbl[15] = '{1'b0, 32'h0,        8'h34, 1'b0};
        tbl[16] = '{1'b0, 32'h0,        8'h56, 1'b0};
        tbl[17] = '{1'b0, 32'h0,        8'h78, 1'b0};
        tbl[18] = '{1'b0, 32'h0,        crc_b, 1'b1};
        tbl[19] = '{1'b0, 32'h0,        8'hC5, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_data",  {24'b0, out_data}, 32'h0);
        chk("rst_oce",   {31'b0, out_oce}, 32'h0);
        chk("rst_ready", {31'b0, msg_ready}, 32'h0);
        chk("rst_count", {16'b0, msg_count}, 32'h0);
        #1 rst = 1'b0;

        // Initial training burst, then idle
        for (int i = 0; i < TC; i++) begin
            @(negedge clk);
            chk("train_byte", {24'b0, out_data}, 32'h5C);
            chk("train_done_low", {31'b0, train_done}, 32'h0);
        end
        @(negedge clk);
        chk("idle_byte", {24'b0, out_data}, 32'hC5);
        chk("idle_done", {31'b0, train_done}, 32'h1);
        chk("idle_ready", {31'b0, msg_ready}, 32'h1);
        chk("idle9_byte", {24'b0, o9}, 32'hC5);

        // Nine-byte ASCII frame on the second instance
        #1 v9 = 1'b1; d9 = 72'h313233343536373839;
        @(negedge clk);
        chk("ascii_sof", {24'b0, o9}, 32'hF5);
        #1 v9 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("ascii_payload", {24'b0, o9}, 32'h31 + k);
        end
        @(negedge clk);
        chk("ascii_crc", {24'b0, o9}, 32'hF4);
        chk("ascii_count", {16'b0, c9}, 32'h1);
        @(negedge clk);
        chk("ascii_idle", {24'b0, o9}, 32'hC5);

        // Vector table: single frame, F5 payload without stuffing, back-to-back frames
        for (int i = 0; i < 20; i++) begin
            #1 msg_valid = tbl[i].v; msg_data = tbl[i].d;
            @(negedge clk);
            chk($sformatf("vec%0d_data", i), {24'b0, out_data}, {24'b0, tbl[i].ed});
            chk($sformatf("vec%0d_ready", i), {31'b0, msg_ready}, {31'b0, tbl[i].er});
        end
        chk("vec_count", {16'b0, msg_count}, 32'd3);

        // Training request while idle
        #1 train_req = 1'b1;
        @(negedge clk);
        chk("idle_treq_byte", {24'b0, out_data}, 32'h5C);
        chk("idle_treq_ready", {31'b0, msg_ready}, 32'h0);
        #1 train_req = 1'b0;
        for (int i = 1; i < TC; i++) @(negedge clk);
        @(negedge clk);
        chk("idle_treq_end", {24'b0, out_data}, 32'hC5);

        // Training request during payload byte 1
        #1 msg_valid = 1'b1; msg_data = 32'hDEADBEEF;
        @(negedge clk);
        #1 msg_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_treq_b1", {24'b0, out_data}, 32'hAD);
        #1 train_req = 1'b1;
        @(negedge clk);
        #1 train_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_treq_crc", {24'b0, out_data}, {24'b0, crc_c});
        chk("mid_treq_crc_ready", {31'b0, msg_ready}, 32'h0);
        for (int i = 0; i < TC; i++) begin
            @(negedge clk);
            chk("mid_treq_train", {24'b0, out_data}, 32'h5C);
        end
        @(negedge clk);
        chk("mid_treq_idle", {24'b0, out_data}, 32'hC5);
        chk("mid_treq_ready", {31'b0, msg_ready}, 32'h1);

        // Counter wrap
        #1 force dut.msg_count = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(negedge clk);
        #1 release dut.msg_count;
        @(negedge clk);
        chk("wrap_pre", {16'b0, msg_count}, 32'hFFFF);
        #1 msg_valid = 1'b1; msg_data = 32'hCAFE0001;
        @(negedge clk);
        #1 msg_valid = 1'b0;
        repeat (ML + 1) @(negedge clk);
        chk("wrap_count", {16'b0, msg_count}, 32'h0);

        // Reset during payload byte 2
        @(negedge clk);
        #1 msg_valid = 1'b1; msg_data = 32'h0A0B0C0D;
        @(negedge clk);
        #1 msg_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_b2", {24'b0, out_data}, 32'h0C);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_data", {24'b0, out_data}, 32'h0);
        chk("abort_oce", {31'b0, out_oce}, 32'h0);
        chk("abort_count", {16'b0, msg_count}, 32'h0);
        #1 rst = 1'b0;
        for (int i = 0; i < TC; i++) begin
            @(negedge clk);
            chk("abort_train", {24'b0, out_data}, 32'h5C);
        end
        @(negedge clk);
        chk("abort_idle", {24'b0, out_data}, 32'hC5);

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            #1;
            msg_valid = 1'($urandom_range(0, 1));
            msg_data  = $urandom;
            train_req = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        #1 msg_valid = 1'b0; train_req = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
